// File: rtl/ad9911_pkg.sv
// Shared constants and types for the AD9911 frequency controller.
//   - serial register addresses and data lengths
//   - default CSR / FR1 values
//   - sequencer state enum and the frame builder used by the SPI writer
package ad9911_pkg;

  localparam logic [4:0] ADDR_CSR  = 5'h00;
  localparam logic [4:0] ADDR_FR1  = 5'h01;
  localparam logic [4:0] ADDR_CTW0 = 5'h04;

  localparam logic [5:0] LEN_CSR  = 6'd8;
  localparam logic [5:0] LEN_FR1  = 6'd24;
  localparam logic [5:0] LEN_CTW0 = 6'd32;

  localparam logic [7:0]  CSR_DEFAULT = 8'hF0;
  localparam logic [23:0] FR1_DEFAULT = 24'hD00000;

  typedef enum logic [2:0] {
    S_RST, S_W_CSR, S_W_FR1, S_W_CTW_INIT, S_IDLE, S_W_CTW
  } seq_state_e;

  // Instruction byte (write, addr) followed by the data, all left-aligned in
  // 40 bits so the writer always shifts out of bit 39. Data arrives
  // right-aligned in 32 bits and is moved up to sit right below the
  // instruction byte.
  function automatic logic [39:0] build_frame(input logic [4:0]  addr,
                                              input logic [31:0] data,
                                              input logic [5:0]  len);
    return {3'b000, addr, data << (6'd32 - len)};
  endfunction

endpackage

// File: rtl/ad9911_spi_writer.sv
// One AD9911 serial write transaction: CS low, B bits MSB first at
// CLOCK_10M/2, CS high for one cycle, a two-cycle IO_UPDATE pulse, then a
// one-cycle done. A new request is accepted in the done cycle.
// Ports:
//   CLOCK_10M, RESET_N    clock, synchronous active-low reset
//   req_i                 start a transaction (sampled while idle)
//   addr_i/data_i/len_i   register address, right-aligned data, data bits
//   done_o                one-cycle completion pulse
//   ad_cs_o/ad_sclk_o/ad_sdio0_o/ad_update_o   AD9911 pins
module ad9911_spi_writer
  import ad9911_pkg::*;
(
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic        req_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  len_i,
  output logic        done_o,
  output logic        ad_cs_o,
  output logic        ad_sclk_o,
  output logic        ad_sdio0_o,
  output logic        ad_update_o
);

  typedef enum logic [2:0] {W_IDLE, W_SHIFT, W_GAP, W_UPD1, W_UPD2} wr_state_e;

  wr_state_e   state_q;
  logic [39:0] sr_q;
  logic [5:0]  bits_q;     // bits still to present after the current one
  logic        cs_q, sclk_q, sdio_q, upd_q, done_q;
  logic [39:0] frame_w;

  assign frame_w = build_frame(addr_i, data_i, len_i);

  always_ff @(posedge CLOCK_10M) begin
    if (!RESET_N) begin
      state_q <= W_IDLE;
      sr_q    <= '0;
      bits_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdio_q  <= 1'b0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        W_IDLE: if (req_i) begin
          cs_q    <= 1'b0;
          sdio_q  <= frame_w[39];
          sr_q    <= {frame_w[38:0], 1'b0};
          bits_q  <= len_i + 6'd7;         // 8 + len bits, first one already out
          state_q <= W_SHIFT;
        end
        W_SHIFT: begin
          if (!sclk_q) begin
            sclk_q <= 1'b1;                  // data set up a full cycle earlier
          end else if (bits_q != 6'd0) begin
            sclk_q <= 1'b0;
            sdio_q <= sr_q[39];
            sr_q   <= {sr_q[38:0], 1'b0};
            bits_q <= bits_q - 6'd1;
          end else begin
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            sdio_q  <= 1'b0;
            state_q <= W_GAP;
          end
        end
        W_GAP: begin
          upd_q   <= 1'b1;
          state_q <= W_UPD1;
        end
        W_UPD1: state_q <= W_UPD2;
        W_UPD2: begin
          upd_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= W_IDLE;
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  assign done_o      = done_q;
  assign ad_cs_o     = cs_q;
  assign ad_sclk_o   = sclk_q;
  assign ad_sdio0_o  = sdio_q;
  assign ad_update_o = upd_q;

endmodule

// File: rtl/ad9911_freq_ctrl.sv
// AD9911 frequency controller: after reset writes CSR, FR1 and CTW0
// (START_FREQW), raises INIT_OK, then rewrites CTW0 on each host request.
// Ports:
//   CLOCK_10M, RESET_N     10 MHz clock, synchronous active-low reset
//   FREQW, FREQW_UPDATE    new tuning word and its one-cycle strobe
//   INIT_OK                init sequence finished (sticky until reset)
//   FREQW_UPDATE_OVER      latest requested CTW0 write has completed
//   AD_CS/AD_SCLK/AD_SDIO0/AD_UPDATE   AD9911 serial pins and IO_UPDATE
module ad9911_freq_ctrl
  import ad9911_pkg::*;
#(
  parameter logic [31:0] START_FREQW = 32'd0,
  parameter logic [7:0]  CSR_VALUE   = CSR_DEFAULT,
  parameter logic [23:0] FR1_VALUE   = FR1_DEFAULT
) (
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic [31:0] FREQW,
  input  logic        FREQW_UPDATE,
  output logic        INIT_OK,
  output logic        FREQW_UPDATE_OVER,
  output logic        AD_CS,
  output logic        AD_SCLK,
  output logic        AD_SDIO0,
  output logic        AD_UPDATE
);

  seq_state_e  state_q;
  logic        req_q;
  logic [4:0]  addr_q;
  logic [31:0] data_q;
  logic [5:0]  len_q;
  logic [31:0] hold_q;
  logic        pend_q, init_ok_q, over_q;
  logic        done_w;

  always_ff @(posedge CLOCK_10M) begin
    if (!RESET_N) begin
      state_q   <= S_RST;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      len_q     <= '0;
      hold_q    <= '0;
      pend_q    <= 1'b0;
      init_ok_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        S_RST: begin
          state_q <= S_W_CSR;
          req_q   <= 1'b1;
          addr_q  <= ADDR_CSR;
          data_q  <= {24'd0, CSR_VALUE};
          len_q   <= LEN_CSR;
        end
        S_W_CSR: if (done_w) begin
          state_q <= S_W_FR1;
          req_q   <= 1'b1;
          addr_q  <= ADDR_FR1;
          data_q  <= {8'd0, FR1_VALUE};
          len_q   <= LEN_FR1;
        end
        S_W_FR1: if (done_w) begin
          state_q <= S_W_CTW_INIT;
          req_q   <= 1'b1;
          addr_q  <= ADDR_CTW0;
          data_q  <= START_FREQW;
          len_q   <= LEN_CTW0;
        end
        S_W_CTW_INIT: if (done_w) begin
          state_q   <= S_IDLE;
          init_ok_q <= 1'b1;
        end
        S_IDLE: if (pend_q) begin
          state_q <= S_W_CTW;
          req_q   <= 1'b1;
          addr_q  <= ADDR_CTW0;
          data_q  <= hold_q;
          len_q   <= LEN_CTW0;
          pend_q  <= 1'b0;
        end
        S_W_CTW: if (done_w) begin
          state_q <= S_IDLE;
          // A newer word is still waiting: this write is not the one asked for.
          if (!pend_q) over_q <= 1'b1;
        end
        default: state_q <= S_RST;
      endcase
      // A host request wins over anything the sequencer did this cycle.
      if (FREQW_UPDATE) begin
        hold_q <= FREQW;
        pend_q <= 1'b1;
        over_q <= 1'b0;
      end
    end
  end

  ad9911_spi_writer u_spi (
    .CLOCK_10M   (CLOCK_10M),
    .RESET_N     (RESET_N),
    .req_i       (req_q),
    .addr_i      (addr_q),
    .data_i      (data_q),
    .len_i       (len_q),
    .done_o      (done_w),
    .ad_cs_o     (AD_CS),
    .ad_sclk_o   (AD_SCLK),
    .ad_sdio0_o  (AD_SDIO0),
    .ad_update_o (AD_UPDATE)
  );

  assign INIT_OK           = init_ok_q;
  assign FREQW_UPDATE_OVER = over_q;

endmodule

// File: tb/tb_ad9911_freq_ctrl.sv
module tb_ad9911_freq_ctrl;
  localparam logic [31:0] START_W = 32'd370440929;

  logic        CLOCK_10M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        FREQW_UPDATE = 1'b0;
  logic [31:0] FREQW = 32'd0;
  logic        INIT_OK, FREQW_UPDATE_OVER, AD_CS, AD_SCLK, AD_SDIO0, AD_UPDATE;

  ad9911_freq_ctrl #(.START_FREQW(START_W)) dut (
    .CLOCK_10M(CLOCK_10M), .RESET_N(RESET_N), .FREQW(FREQW),
    .FREQW_UPDATE(FREQW_UPDATE), .INIT_OK(INIT_OK),
    .FREQW_UPDATE_OVER(FREQW_UPDATE_OVER), .AD_CS(AD_CS), .AD_SCLK(AD_SCLK),
    .AD_SDIO0(AD_SDIO0), .AD_UPDATE(AD_UPDATE));

  always #50 CLOCK_10M = ~CLOCK_10M;

  int n_tests = 0, n_fail = 0, cyc = 0;

  // Transaction-level model: phase of the init/update flow, position m_k in
  // the current transaction's cycle timeline (request cycle = 0), and the frame.
  int          m_phase = 0;   // 0 rst,1 csr,2 fr1,3 ctw-init,4 idle,5 ctw
  int          m_k = -1, m_B = 16;
  logic [39:0] m_frame = '0;
  logic        m_pend = 0, m_init_ok = 0, m_over = 0, m_rst_last = 1;
  logic [31:0] m_hold = '0;
  int          exp_len[$];
  logic [39:0] exp_val[$];

  // Pin decoder: every completed frame (bit count, right-aligned value).
  int          log_len[$];
  logic [39:0] log_val[$];
  int          cmp_idx = 0, d_cnt = 0;
  logic [39:0] d_val = '0;
  logic        prev_cs = 1, prev_sclk = 0, prev_sdio = 0;

  function automatic logic [39:0] mk_frame(input logic [4:0] a, input logic [31:0] d,
                                           input int dlen);
    logic [39:0] r;
    r = (40'(a) << dlen) | (40'(d) & ((40'd1 << dlen) - 40'd1));
    return r << (32 - dlen);
  endfunction

  task automatic start_txn(input logic [4:0] a, input logic [31:0] d, input int dlen);
    m_k = 0; m_B = 8 + dlen; m_frame = mk_frame(a, d, dlen);
  endtask

  task automatic model_edge(input logic r, input logic u, input logic [31:0] f);
    bit done_c;
    m_rst_last = !r;
    if (!r) begin
      m_phase = 0; m_k = -1; m_pend = 0; m_init_ok = 0; m_over = 0;
      return;
    end
    done_c = (m_k == 2 * m_B + 4);
    if (m_phase == 0) begin
      m_phase = 1; start_txn(5'h00, 32'hF0, 8);
    end else if (done_c) begin
      case (m_phase)
        1: begin m_phase = 2; start_txn(5'h01, 32'hD00000, 24); end
        2: begin m_phase = 3; start_txn(5'h04, START_W, 32); end
        3: begin m_phase = 4; m_k = -1; m_init_ok = 1; end
        default: begin m_phase = 4; m_k = -1; if (!m_pend) m_over = 1; end
      endcase
    end else if (m_phase == 4 && m_pend) begin
      m_phase = 5; start_txn(5'h04, m_hold, 32); m_pend = 0;
    end else if (m_k >= 0) m_k++;
    if (u) begin m_hold = f; m_pend = 1; m_over = 0; end
    if (m_k == 2 * m_B + 1) begin
      exp_len.push_back(m_B); exp_val.push_back(m_frame >> (40 - m_B));
    end
  endtask

  task automatic check_cycle();
    logic e_cs, e_sclk, e_upd, e_sdio;
    bit   sdio_chk, in_frame;
    in_frame = (m_k >= 1 && m_k <= 2 * m_B);
    e_cs   = !in_frame;
    e_sclk = in_frame && (m_k % 2 == 0);
    e_upd  = (m_k == 2 * m_B + 2) || (m_k == 2 * m_B + 3);
    sdio_chk = in_frame || m_rst_last;
    e_sdio = in_frame ? m_frame[39 - (m_k - 1) / 2] : 1'b0;
    n_tests++;
    if (AD_CS !== e_cs || AD_SCLK !== e_sclk || AD_UPDATE !== e_upd ||
        INIT_OK !== m_init_ok || FREQW_UPDATE_OVER !== m_over ||
        (sdio_chk && AD_SDIO0 !== e_sdio)) begin
      n_fail++;
      $display("FAIL pins cyc=%0d got cs=%b sclk=%b sdio=%b upd=%b init_ok=%b over=%b want cs=%b sclk=%b sdio=%b upd=%b init_ok=%b over=%b",
               cyc, AD_CS, AD_SCLK, AD_SDIO0, AD_UPDATE, INIT_OK, FREQW_UPDATE_OVER,
               e_cs, e_sclk, e_sdio, e_upd, m_init_ok, m_over);
    end
    if (AD_SCLK === 1'b1) begin
      n_tests++;
      if (AD_SDIO0 !== prev_sdio || prev_sclk !== 1'b0) begin
        n_fail++;
        $display("FAIL sclk_shape cyc=%0d got sdio=%b prev_sdio=%b prev_sclk=%b want sdio held, prev_sclk=0",
                 cyc, AD_SDIO0, prev_sdio, prev_sclk);
      end
    end
    if (m_rst_last) begin
      d_cnt = 0; d_val = '0;
    end else begin
      if (!AD_CS && AD_SCLK && !prev_sclk) begin d_val = {d_val[38:0], AD_SDIO0}; d_cnt++; end
      if (AD_CS && !prev_cs) begin
        log_len.push_back(d_cnt); log_val.push_back(d_val); d_cnt = 0; d_val = '0;
      end
    end
    prev_cs = AD_CS; prev_sclk = AD_SCLK; prev_sdio = AD_SDIO0;
    while (exp_len.size() > 0 && cmp_idx < log_len.size()) begin
      int el; logic [39:0] ev;
      el = exp_len.pop_front(); ev = exp_val.pop_front();
      n_tests++;
      if (log_len[cmp_idx] != el || log_val[cmp_idx] !== ev) begin
        n_fail++;
        $display("FAIL frame#%0d got %0d bits %h want %0d bits %h",
                 cmp_idx, log_len[cmp_idx], log_val[cmp_idx], el, ev);
      end
      cmp_idx++;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_10M);
    model_edge(RESET_N, FREQW_UPDATE, FREQW);
    #1;
    check_cycle();
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic chk_frame(input string name, input int idx, input int len, input logic [39:0] val);
    n_tests++;
    if (idx >= log_len.size()) begin
      n_fail++;
      $display("FAIL %s got no frame #%0d want %0d bits %h", name, idx, len, val);
    end else if (log_len[idx] != len || log_val[idx] !== val) begin
      n_fail++;
      $display("FAIL %s got %0d bits %h want %0d bits %h", name, log_len[idx], log_val[idx], len, val);
    end
  endtask

  task automatic pulse_update(input logic [31:0] w);
    FREQW_UPDATE = 1; FREQW = w;
    tick();
    FREQW_UPDATE = 0; FREQW = $urandom;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (INIT_OK !== 1'b1 && n < 400) begin tick(); n++; end
  endtask

  task automatic wait_over(output int n);
    n = 0;
    while (FREQW_UPDATE_OVER !== 1'b1 && n < 400) begin tick(); n++; end
  endtask

  task automatic check_init_frames(input int base);
    chk_frame("init_csr", base, 16, 40'h00F0);
    chk_frame("init_fr1", base + 1, 32, 40'h01D00000);
    chk_frame("init_ctw", base + 2, 40, {8'h04, 32'd370440929});
  endtask

  initial begin
    int n, base;
    // Reset state
    RESET_N = 0;
    repeat (3) tick();
    chk("rst_outs", {58'd0, AD_CS, AD_SCLK, AD_SDIO0, AD_UPDATE, INIT_OK, FREQW_UPDATE_OVER},
        {58'd0, 6'b100000});
    // Init sequence
    RESET_N = 1;
    wait_init(n);
    chk("init_ok_by_195", 64'(INIT_OK === 1'b1 && n <= 195), 64'd1);
    check_init_frames(0);
    // Single update from idle
    pulse_update(32'h1234_5678);
    wait_over(n);
    chk("upd1_within_87", 64'(FREQW_UPDATE_OVER === 1'b1 && n + 1 <= 87), 64'd1);
    chk_frame("upd1_frame", 3, 40, 40'h04_1234_5678);
    repeat (5) tick();
    chk("upd1_over_held", 64'(FREQW_UPDATE_OVER), 64'd1);
    // Two requests during one CTW0 write collapse into one further frame
    pulse_update(32'h0000_0009);
    chk("over_drops", 64'(FREQW_UPDATE_OVER), 64'd0);
    repeat (20) tick();
    pulse_update(32'h0000_0001);
    repeat (10) tick();
    pulse_update(32'h0000_0002);
    wait_over(n);
    chk("collapse_done", 64'(FREQW_UPDATE_OVER), 64'd1);
    chk("collapse_count", 64'(log_len.size()), 64'd6);
    chk_frame("collapse_first", 4, 40, 40'h04_0000_0009);
    chk_frame("collapse_last", 5, 40, 40'h04_0000_0002);
    // Update during init
    RESET_N = 0; tick(); RESET_N = 1;
    base = log_len.size();
    repeat (50) tick();
    pulse_update(32'hAAAA_5555);
    wait_init(n);
    check_init_frames(base);
    wait_over(n);
    chk_frame("init_upd_frame", base + 3, 40, 40'h04_AAAA_5555);
    chk("init_upd_count", 64'(log_len.size() - base), 64'd4);
    // One-cycle reset in the middle of a frame
    pulse_update(32'hCAFE_F00D);
    repeat (30) tick();
    base = log_len.size();
    RESET_N = 0; tick();
    chk("midframe_rst", {58'd0, AD_CS, AD_SCLK, AD_SDIO0, AD_UPDATE, INIT_OK, FREQW_UPDATE_OVER},
        {58'd0, 6'b100000});
    RESET_N = 1;
    wait_init(n);
    chk("restart_no_partial", 64'(log_len.size() - base), 64'd3);
    check_init_frames(base);
    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      FREQW_UPDATE = ($urandom_range(0, 39) == 0);
      FREQW = $urandom;
      RESET_N = ($urandom_range(0, 699) != 0);
      tick();
    end
    FREQW_UPDATE = 0; RESET_N = 1;
    repeat (400) tick();
    chk("frames_all_matched", 64'(exp_len.size() == 0 && cmp_idx == log_len.size()), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
